// File: rtl/morty_ifetch_wb_pkg.sv
// Shared fetch-master definitions: NOP word, bus select and FSM encoding.
// Imported by the instruction-fetch master and its bus timer.
package morty_ifetch_wb_pkg;

    localparam logic [31:0] MORTY_NOP = 32'h0000_0013;
    localparam logic [3:0]  WB_SEL    = 4'hF;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_BUSY  = 2'd1,
        FETCH_ABORT = 2'd2,
        FETCH_VALID = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/morty_bus_timer.sv
// Saturating wait-state counter for Wishbone masters.
// expired_o flags the last permitted wait cycle; TIMEOUT=0 never expires.
module morty_bus_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] CAP  = TW'(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != CAP)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (TIMEOUT != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/morty_ifetch_wb.sv
// Instruction-fetch Wishbone classic master feeding the IF stage.
// Buffers one fetched word while the pipeline holds; discards fetches on flush.
module morty_ifetch_wb
    import morty_ifetch_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = MORTY_NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_flush_i,
    input  logic        if_hold_i,
    output logic [31:0] if_instruction_o,
    output logic        if_inst_access_fault_o,
    output logic        if_stall_o,
    output logic [31:0] iwbm_addr_o,
    output logic [3:0]  iwbm_sel_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  inst_q, inst_d;
    logic         fault_q, fault_d;
    logic         cyc_q, cyc_d;
    logic         timer_clear;
    logic         timer_en;
    logic         timer_expired;
    logic         term;

    assign timer_en = (state_q == FETCH_BUSY) || (state_q == FETCH_ABORT);

    morty_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    assign term = iwbm_ack_i || iwbm_err_i || timer_expired;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        fault_d     = fault_q;
        cyc_d       = cyc_q;
        timer_clear = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (!if_flush_i) begin
                    if (if_pc_i[1:0] != 2'b00) begin
                        inst_d  = NOP_INST;
                        fault_d = 1'b0;
                        state_d = FETCH_VALID;
                    end else begin
                        addr_d      = word_addr(if_pc_i);
                        cyc_d       = 1'b1;
                        timer_clear = 1'b1;
                        state_d     = FETCH_BUSY;
                    end
                end
            end
            FETCH_BUSY: begin
                if (term) begin
                    cyc_d = 1'b0;
                    if (if_flush_i) begin
                        state_d = FETCH_IDLE;
                    end else begin
                        state_d = FETCH_VALID;
                        // ack wins over a simultaneous err
                        if (iwbm_ack_i) begin
                            inst_d  = iwbm_dat_i;
                            fault_d = 1'b0;
                        end else begin
                            inst_d  = NOP_INST;
                            fault_d = 1'b1;
                        end
                    end
                end else if (if_flush_i) begin
                    state_d = FETCH_ABORT;
                end
            end
            FETCH_ABORT: begin
                if (term) begin
                    cyc_d   = 1'b0;
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_VALID: begin
                if (if_flush_i || !if_hold_i) begin
                    state_d = FETCH_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            fault_q <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cyc_q   <= cyc_d;
        end
    end

    assign if_stall_o             = (state_q != FETCH_VALID);
    assign if_instruction_o       = inst_q;
    assign if_inst_access_fault_o = fault_q;
    assign iwbm_addr_o            = addr_q;
    assign iwbm_sel_o             = WB_SEL;
    assign iwbm_cyc_o             = cyc_q;
    assign iwbm_stb_o             = cyc_q;

endmodule
